// File: rtl/issue_queue.sv
// issue_queue: collapsing out-of-order issue queue.
//
// Holds renamed uops from map until both physical source operands are ready,
// then issues the oldest ready entry. Entry 0 is always the oldest, and valid
// entries stay packed from index 0 upward.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop every entry on the next edge
//   enq_valid/enq_uop   uop arriving from map
//   enq_ready           space available (count < DEPTH)
//   busy_rs1/2_addr     busy-table lookup addresses (enq_uop sources)
//   busy_rs1/2          busy-table bits returned in the same cycle
//   wakeup_valid/tag    writeback broadcast of a freshly written register
//   issue_valid/uop     oldest ready entry, handshaked with issue_ready
//   count               number of occupied entries

package issue_queue_pkg;
  localparam int PHY_RF_DEPTH = 128;
  localparam int PTW          = $clog2(PHY_RF_DEPTH);

  // Physical-register view of a uop, as produced by map.
  typedef struct packed {
    logic [PTW-1:0] rd;
    logic [PTW-1:0] rs1;
    logic [PTW-1:0] rs2;
    logic           rd_valid;
    logic           rs1_valid;
    logic           rs2_valid;
  } uop_ic_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  opcode;
    uop_ic_t     uop_ic;
  } uop_t;
endpackage

module issue_queue #(
  parameter int  DEPTH        = 8,
  parameter int  PHY_RF_DEPTH = issue_queue_pkg::PHY_RF_DEPTH,
  localparam int PTW          = $clog2(PHY_RF_DEPTH),
  localparam int IW           = $clog2(DEPTH),
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  issue_queue_pkg::uop_t enq_uop,
  output logic                  enq_ready,
  output logic [PTW-1:0]        busy_rs1_addr,
  output logic [PTW-1:0]        busy_rs2_addr,
  input  logic                  busy_rs1,
  input  logic                  busy_rs2,
  input  logic                  wakeup_valid,
  input  logic [PTW-1:0]        wakeup_tag,
  output logic                  issue_valid,
  output issue_queue_pkg::uop_t issue_uop,
  input  logic                  issue_ready,
  output logic [CW-1:0]         count
);

  logic                  valid_q [DEPTH];
  logic                  valid_d [DEPTH];
  issue_queue_pkg::uop_t uop_q   [DEPTH];
  issue_queue_pkg::uop_t uop_d   [DEPTH];
  logic                  r1_q    [DEPTH];
  logic                  r1_d    [DEPTH];
  logic                  r2_q    [DEPTH];
  logic                  r2_d    [DEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          enq_fire;
  logic          issue_fire;
  logic          enq_r1;
  logic          enq_r2;
  logic [CW-1:0] enq_pos;

  assign busy_rs1_addr = enq_uop.uop_ic.rs1;
  assign busy_rs2_addr = enq_uop.uop_ic.rs2;
  assign count         = count_q;
  assign enq_ready     = (count_q < CW'(DEPTH));
  assign enq_fire      = enq_valid && enq_ready;
  assign issue_fire    = sel_found && issue_ready;
  assign issue_valid   = sel_found;
  assign issue_uop     = uop_q[sel_idx];

  // A wakeup in the enqueue cycle is folded into the initial readiness so it
  // is not missed; tag 0 is the hardwired zero register and never busy.
  assign enq_r1 = !enq_uop.uop_ic.rs1_valid || (enq_uop.uop_ic.rs1 == '0) || !busy_rs1 ||
                  (wakeup_valid && (wakeup_tag == enq_uop.uop_ic.rs1));
  assign enq_r2 = !enq_uop.uop_ic.rs2_valid || (enq_uop.uop_ic.rs2 == '0) || !busy_rs2 ||
                  (wakeup_valid && (wakeup_tag == enq_uop.uop_ic.rs2));

  // Oldest-ready select: scan downward so the lowest index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && r1_q[i] && r2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Next state: collapse over the issued slot, then wakeup, then enqueue.
  // With an issue the tail moves down by one, so the new uop lands at count-1.
  always_comb begin
    count_d = count_q + CW'(enq_fire) - CW'(issue_fire);
    enq_pos = count_q - CW'(issue_fire);

    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      uop_d[i]   = uop_q[i];
      r1_d[i]    = r1_q[i];
      r2_d[i]    = r2_q[i];

      if (issue_fire && (IW'(i) >= sel_idx)) begin
        if (i == DEPTH - 1) begin
          valid_d[i] = 1'b0;
          r1_d[i]    = 1'b0;
          r2_d[i]    = 1'b0;
        end else begin
          valid_d[i] = valid_q[(i + 1) % DEPTH];
          uop_d[i]   = uop_q[(i + 1) % DEPTH];
          r1_d[i]    = r1_q[(i + 1) % DEPTH];
          r2_d[i]    = r2_q[(i + 1) % DEPTH];
        end
      end

      if (wakeup_valid && valid_d[i]) begin
        if (uop_d[i].uop_ic.rs1_valid && (uop_d[i].uop_ic.rs1 == wakeup_tag)) r1_d[i] = 1'b1;
        if (uop_d[i].uop_ic.rs2_valid && (uop_d[i].uop_ic.rs2 == wakeup_tag)) r2_d[i] = 1'b1;
      end

      if (enq_fire && (CW'(i) == enq_pos)) begin
        valid_d[i] = 1'b1;
        uop_d[i]   = enq_uop;
        r1_d[i]    = enq_r1;
        r2_d[i]    = enq_r2;
      end

      if (flush) begin
        valid_d[i] = 1'b0;
        r1_d[i]    = 1'b0;
        r2_d[i]    = 1'b0;
      end
    end

    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        uop_q[i]   <= '0;
        r1_q[i]    <= 1'b0;
        r2_q[i]    <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        uop_q[i]   <= uop_d[i];
        r1_q[i]    <= r1_d[i];
        r2_q[i]    <= r2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: self-checking bench for issue_queue.
// Issued uops are checked against a scoreboard queue filled in expected issue
// order; each scenario task also checks count/valid/ready inline.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       enq_valid = 1'b0;
  uop_t       enq_uop = '0;
  logic       enq_ready;
  logic [6:0] busy_rs1_addr, busy_rs2_addr;
  logic       busy_rs1 = 1'b0, busy_rs2 = 1'b0;
  logic       wakeup_valid = 1'b0;
  logic [6:0] wakeup_tag = '0;
  logic       issue_valid;
  uop_t       issue_uop;
  logic       issue_ready = 1'b0;
  logic [3:0] count;

  int   total_cnt = 0;
  int   pass_cnt = 0;
  uop_t exp_q[$];
  uop_t exp_uop;

  issue_queue #(.DEPTH(DEPTH), .PHY_RF_DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_uop(enq_uop), .enq_ready(enq_ready),
    .busy_rs1_addr(busy_rs1_addr), .busy_rs2_addr(busy_rs2_addr),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .issue_valid(issue_valid), .issue_uop(issue_uop), .issue_ready(issue_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issue handshake must match the next expected uop.
  always @(negedge clk) begin
    if (rst_n && !flush && issue_valid && issue_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_unexpected: got pc=%h, expected no issue", issue_uop.pc);
      end else begin
        exp_uop = exp_q.pop_front();
        if (issue_uop !== exp_uop)
          $display("FAIL issue_uop: got pc=%h uop=%h, expected pc=%h uop=%h",
                   issue_uop.pc, issue_uop, exp_uop.pc, exp_uop);
        else begin
          pass_cnt++;
          $display("issue pc=%h ok", issue_uop.pc);
        end
      end
    end
  end

  function automatic uop_t mk(input logic [31:0] pc, input logic [6:0] rs1, input logic v1,
                              input logic [6:0] rs2, input logic v2);
    uop_t u;
    u = '0;
    u.pc = pc;
    u.opcode = pc[7:0] ^ 8'h5a;
    u.uop_ic.rd = pc[8:2];
    u.uop_ic.rd_valid = 1'b1;
    u.uop_ic.rs1 = rs1;
    u.uop_ic.rs1_valid = v1;
    u.uop_ic.rs2 = rs2;
    u.uop_ic.rs2_valid = v2;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input uop_t u, input logic b1, input logic b2);
    enq_valid = 1'b1;
    enq_uop = u;
    busy_rs1 = b1;
    busy_rs2 = b2;
  endtask

  task automatic idle_enq();
    enq_valid = 1'b0;
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (count !== 4'd0) $display("FAIL reset_count: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b, expected 1", enq_ready); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b, expected 0", issue_valid); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL post_reset_count: got %0d, expected 0", count); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    uop_t u;
    issue_ready = 1'b1;
    u = mk(32'h100, 7'd5, 1'b1, 7'd7, 1'b1);
    drive_enq(u, 1'b0, 1'b0);
    #1;
    total_cnt++; if (busy_rs1_addr !== 7'd5) $display("FAIL busy_rs1_addr: got %0d, expected 5", busy_rs1_addr); else pass_cnt++;
    total_cnt++; if (busy_rs2_addr !== 7'd7) $display("FAIL busy_rs2_addr: got %0d, expected 7", busy_rs2_addr); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL empty_issue_valid: got %b, expected 0", issue_valid); else pass_cnt++;
    exp_q.push_back(u);
    tick(); idle_enq();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL basic_issue_valid: got %b, expected 1", issue_valid); else pass_cnt++;
    total_cnt++; if (count !== 4'd1) $display("FAIL basic_count1: got %0d, expected 1", count); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL basic_count0: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL basic_drained: got %b, expected 0", issue_valid); else pass_cnt++;
    // An invalid source is ready even if the busy bit says otherwise.
    u = mk(32'h104, 7'd20, 1'b0, 7'd0, 1'b1);
    drive_enq(u, 1'b1, 1'b1);
    exp_q.push_back(u);
    tick(); idle_enq();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL invalid_src_ready: got %b, expected 1", issue_valid); else pass_cnt++;
    tick();
    issue_ready = 1'b0;
    $display("test_basic done");
  endtask

  task automatic test_wakeup();
    uop_t a, b, c;
    issue_ready = 1'b1;
    a = mk(32'h300, 7'd9, 1'b1, 7'd0, 1'b1);
    b = mk(32'h304, 7'd3, 1'b1, 7'd4, 1'b1);
    drive_enq(a, 1'b1, 1'b0);
    tick();
    drive_enq(b, 1'b0, 1'b0);
    exp_q.push_back(b);
    tick(); idle_enq();
    total_cnt++; if (count !== 4'd2) $display("FAIL wake_count2: got %0d, expected 2", count); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL wake_b_ready: got %b, expected 1", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd1) $display("FAIL wake_count1: got %0d, expected 1", count); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wake_a_waits: got %b, expected 0", issue_valid); else pass_cnt++;
    wakeup_valid = 1'b1; wakeup_tag = 7'd10;
    tick(); wakeup_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wake_wrong_tag: got %b, expected 0", issue_valid); else pass_cnt++;
    wakeup_valid = 1'b1; wakeup_tag = 7'd9;
    exp_q.push_back(a);
    tick(); wakeup_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL wake_a_ready: got %b, expected 1", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL wake_count0: got %0d, expected 0", count); else pass_cnt++;
    // Wakeup landing in the enqueue cycle.
    c = mk(32'h308, 7'd9, 1'b1, 7'd9, 1'b1);
    drive_enq(c, 1'b1, 1'b1);
    wakeup_valid = 1'b1; wakeup_tag = 7'd9;
    exp_q.push_back(c);
    tick(); idle_enq(); wakeup_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL wake_same_cycle: got %b, expected 1", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL wake_same_count: got %0d, expected 0", count); else pass_cnt++;
    issue_ready = 1'b0;
    $display("test_wakeup done");
  endtask

  task automatic test_fill();
    uop_t u;
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      u = mk(32'h200 + 32'(4 * i), 7'(i + 1), 1'b1, 7'd0, 1'b0);
      drive_enq(u, 1'b0, 1'b0);
      #1;
      total_cnt++; if (enq_ready !== 1'b1) $display("FAIL fill_enq_ready[%0d]: got %b, expected 1", i, enq_ready); else pass_cnt++;
      exp_q.push_back(u);
      tick();
    end
    idle_enq();
    total_cnt++; if (count !== 4'd8) $display("FAIL fill_count8: got %0d, expected 8", count); else pass_cnt++;
    total_cnt++; if (enq_ready !== 1'b0) $display("FAIL fill_full: got %b, expected 0", enq_ready); else pass_cnt++;
    drive_enq(mk(32'h999, 7'd1, 1'b1, 7'd0, 1'b0), 1'b0, 1'b0);
    tick();
    total_cnt++; if (count !== 4'd8) $display("FAIL fill_9th_ignored: got %0d, expected 8", count); else pass_cnt++;
    issue_ready = 1'b1;
    #1;
    total_cnt++; if (enq_ready !== 1'b0) $display("FAIL full_with_issue: got %b, expected 0", enq_ready); else pass_cnt++;
    tick(); idle_enq();
    total_cnt++; if (count !== 4'd7) $display("FAIL fill_count7: got %0d, expected 7", count); else pass_cnt++;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    issue_ready = 1'b0;
    total_cnt++; if (count !== 4'd0) $display("FAIL fill_drained: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL fill_leftover: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    $display("test_fill done");
  endtask

  task automatic test_simultaneous();
    uop_t o0, o1, o2, n;
    issue_ready = 1'b0;
    o0 = mk(32'h400, 7'd21, 1'b1, 7'd0, 1'b0);
    o1 = mk(32'h404, 7'd1, 1'b1, 7'd0, 1'b0);
    o2 = mk(32'h408, 7'd22, 1'b1, 7'd0, 1'b0);
    n  = mk(32'h40c, 7'd2, 1'b1, 7'd0, 1'b0);
    drive_enq(o0, 1'b1, 1'b0); tick();
    drive_enq(o1, 1'b0, 1'b0); tick();
    drive_enq(o2, 1'b1, 1'b0); tick();
    drive_enq(n, 1'b0, 1'b0);
    issue_ready = 1'b1;
    exp_q.push_back(o1);
    #1;
    total_cnt++; if (count !== 4'd3) $display("FAIL simul_count_before: got %0d, expected 3", count); else pass_cnt++;
    tick(); idle_enq(); issue_ready = 1'b0;
    total_cnt++; if (count !== 4'd3) $display("FAIL simul_count_after: got %0d, expected 3", count); else pass_cnt++;
    wakeup_valid = 1'b1; wakeup_tag = 7'd21; tick();
    wakeup_tag = 7'd22; tick();
    wakeup_valid = 1'b0;
    exp_q.push_back(o0); exp_q.push_back(o2); exp_q.push_back(n);
    issue_ready = 1'b1;
    tick(); tick(); tick();
    issue_ready = 1'b0;
    total_cnt++; if (count !== 4'd0) $display("FAIL simul_drained: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL simul_leftover: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    $display("test_simultaneous done");
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(mk(32'h500 + 32'(4 * i), 7'd3, 1'b1, 7'd0, 1'b0), 1'b0, 1'b0);
      tick();
    end
    idle_enq();
    total_cnt++; if (count !== 4'd4) $display("FAIL flush_count4: got %0d, expected 4", count); else pass_cnt++;
    flush = 1'b1;
    drive_enq(mk(32'h5f0, 7'd3, 1'b1, 7'd0, 1'b0), 1'b0, 1'b0);
    wakeup_valid = 1'b1; wakeup_tag = 7'd3;
    tick();
    flush = 1'b0; idle_enq(); wakeup_valid = 1'b0;
    total_cnt++; if (count !== 4'd0) $display("FAIL flush_count0: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL flush_issue_valid: got %b, expected 0", issue_valid); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL flush_not_stored: got %0d, expected 0", count); else pass_cnt++;
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_enq(mk(32'h600 + 32'(4 * i), 7'd4, 1'b1, 7'd0, 1'b0), 1'b0, 1'b0);
      tick();
    end
    idle_enq();
    total_cnt++; if (count !== 4'd5) $display("FAIL rstmid_count5: got %0d, expected 5", count); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (count !== 4'd0) $display("FAIL rstmid_count: got %0d, expected 0", count); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL rstmid_issue_valid: got %b, expected 0", issue_valid); else pass_cnt++;
    total_cnt++; if (enq_ready !== 1'b1) $display("FAIL rstmid_enq_ready: got %b, expected 1", enq_ready); else pass_cnt++;
    issue_ready = 1'b1;
    tick(); tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL rstmid_held: got %b, expected 0", issue_valid); else pass_cnt++;
    issue_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (count !== 4'd0) $display("FAIL rstmid_release: got %0d, expected 0", count); else pass_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_fill();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
